// File: rtl/vec_pkg.sv
// Shared definitions for the multi-cycle vector shift engine: mode encodings and FSM states.
package vec_pkg;

    localparam logic [1:0] MODE_ROL = 2'b00;
    localparam logic [1:0] MODE_ROR = 2'b01;
    localparam logic [1:0] MODE_LSL = 2'b10;
    localparam logic [1:0] MODE_ASR = 2'b11;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_t;

endpackage

// File: rtl/vec_shift_step.sv
// One combinational shift/rotate step of 0..STEP bit positions over a WIDTH-bit vector.
module vec_shift_step
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned STEP  = 8
) (
    input  logic [WIDTH-1:0]             vec,
    input  logic [1:0]                   mode,
    input  logic [$clog2(STEP+1)-1:0]    amount,
    output logic [WIDTH-1:0]             result
);

    // Rotates use the complementary shift; amount 0 makes it a shift by WIDTH, which yields 0.
    always_comb begin
        result = vec;
        case (mode)
            MODE_ROL: result = (vec << amount) | (vec >> (WIDTH - 32'(amount)));
            MODE_ROR: result = (vec >> amount) | (vec << (WIDTH - 32'(amount)));
            MODE_LSL: result = vec << amount;
            MODE_ASR: result = $unsigned($signed(vec) >>> amount);
            default:  result = vec;
        endcase
    end

endmodule

// File: rtl/vec_shift_engine.sv
// Multi-cycle shift/rotate engine: accepts a vector, shifts at most STEP positions per clock,
// and returns the result over a valid/ready handshake.
module vec_shift_engine
    import vec_pkg::*;
#(
    parameter int unsigned WIDTH = 100,
    parameter int unsigned STEP  = 8,
    parameter int unsigned AMT_W = 8
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [1:0]       in_mode,
    input  logic [AMT_W-1:0] in_amount,
    input  logic             abort,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             busy
);

    localparam int unsigned SW = $clog2(STEP + 1);
    localparam int unsigned CW = (AMT_W > SW) ? AMT_W : SW;

    state_t           state;
    logic [WIDTH-1:0] work;
    logic [1:0]       mode;
    logic [AMT_W-1:0] remaining;
    logic [SW-1:0]    step_amt;
    logic [AMT_W-1:0] rem_next;
    logic [WIDTH-1:0] shifted;

    // Step size is min(remaining, STEP), compared at a width that holds both.
    always_comb begin
        step_amt = SW'(STEP);
        if (CW'(remaining) < CW'(STEP)) begin
            step_amt = SW'(remaining);
        end
        rem_next = remaining - AMT_W'(step_amt);
    end

    vec_shift_step #(
        .WIDTH (WIDTH),
        .STEP  (STEP)
    ) u_step (
        .vec    (work),
        .mode   (mode),
        .amount (step_amt),
        .result (shifted)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= IDLE;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
            out_data  <= '0;
            remaining <= '0;
            work      <= '0;
            mode      <= MODE_ROL;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid && in_ready) begin
                        work      <= in_data;
                        mode      <= in_mode;
                        remaining <= in_amount;
                        in_ready  <= 1'b0;
                        if (in_amount != '0) begin
                            state <= RUN;
                            busy  <= 1'b1;
                        end else begin
                            state     <= DONE;
                            out_valid <= 1'b1;
                            out_data  <= in_data;
                        end
                    end
                end
                RUN: begin
                    if (abort) begin
                        state     <= IDLE;
                        busy      <= 1'b0;
                        in_ready  <= 1'b1;
                        remaining <= '0;
                    end else begin
                        work      <= shifted;
                        remaining <= rem_next;
                        if (rem_next == '0) begin
                            state     <= DONE;
                            busy      <= 1'b0;
                            out_valid <= 1'b1;
                            out_data  <= shifted;
                        end
                    end
                end
                DONE: begin
                    // abort and a normal handshake both release the result; abort simply wins.
                    if (abort || out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state    <= IDLE;
                    in_ready <= 1'b1;
                    busy     <= 1'b0;
                end
            endcase
        end
    end

endmodule
